// File: rtl/mem_access.sv
// Memory stage of the RV32I pipeline: issues loads/stores over a req/ack port,
// stalls upstream while an access is outstanding and produces the writeback value.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] result,
    input  logic [31:0] data,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] rdMem,
    output logic        mem_err,
    output logic [1:0]  err_cause,
    output logic [31:0] err_addr
);
    // state | meaning
    // IDLE  | ready to evaluate the instruction from execute
    // WAIT  | access outstanding, mem_req held until ack or timeout
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   rdmem_q, rdmem_d;
    logic          mem_err_q, mem_err_d;
    logic [1:0]    err_cause_q, err_cause_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic        is_load, is_store, is_mem, legal, aligned, idle, accept;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign idle     = (state_q == S_IDLE);

    always_comb begin
        legal = 1'b0;
        if (is_load)
            legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        else if (is_store)
            legal = (funct3 < 3'b011);
        case (funct3[1:0])
            2'b01:   aligned = ~result[0];
            2'b10:   aligned = (result[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign accept = idle & valid_in & is_mem & aligned & legal;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        f3_d        = f3_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        rdmem_d     = rdmem_q;
        mem_err_d   = 1'b0;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;
        if (idle) begin
            if (valid_in && !is_mem) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_in;
                rdmem_d    = result;
            end else if (accept) begin
                state_d = S_WAIT;
                cnt_d   = '0;
                addr_d  = result;
                we_d    = is_store;
                f3_d    = funct3;
                rd_d    = rd_in;
                wdata_d = 32'd0;
                wstrb_d = 4'b0000;
                if (is_store) begin
                    case (funct3[1:0])
                        2'b00: begin
                            wdata_d = {4{data[7:0]}};
                            wstrb_d = 4'b0001 << result[1:0];
                        end
                        2'b01: begin
                            wdata_d = {2{data[15:0]}};
                            wstrb_d = result[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                            wdata_d = data;
                            wstrb_d = 4'b1111;
                        end
                    endcase
                end
            end else if (valid_in) begin
                // memory op rejected: illegal encoding takes precedence over alignment
                mem_err_d   = 1'b1;
                err_cause_d = legal ? 2'b01 : 2'b10;
                err_addr_d  = result;
            end
        end else begin
            if (mem_ack) begin
                state_d = S_IDLE;
                if (!we_q) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    rdmem_d    = ld_val;
                end
            end else if (cnt_q == CNT_LAST) begin
                state_d     = S_IDLE;
                mem_err_d   = 1'b1;
                err_cause_d = 2'b11;
                err_addr_d  = addr_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            rd_q        <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            rdmem_q     <= '0;
            mem_err_q   <= 1'b0;
            err_cause_q <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            rdmem_q     <= rdmem_d;
            mem_err_q   <= mem_err_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign stall     = accept | (~idle & ~mem_ack);
    assign mem_req   = ~idle;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign rdMem     = rdmem_q;
    assign mem_err   = mem_err_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of single accesses plus
// sequences for ack latency, timeout and reset during an outstanding access.
module tb_mem_access;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] result, data;
    logic [4:0]  rd_in;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] rdMem;
    logic        mem_err;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    int n_vec = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .funct3(funct3),
        .result(result), .data(data), .rd_in(rd_in), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rdMem(rdMem), .mem_err(mem_err), .err_cause(err_cause), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        valid_in = 1'b1;
        opcode   = op;
        funct3   = f3;
        result   = a;
        data     = d;
        rd_in    = rd;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        exp_stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_rdmem;
        logic        exp_err;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int stalls;
        int req_cycles;

        vecs[0]  = '{ALU, 3'b000, 32'h5,   32'h0,        32'h0,        5'd3,  1'b0, 1'b0, 32'h0,   1'b0, 4'h0,    32'h0,        1'b1, 32'h5,        1'b0, 2'b00};
        vecs[1]  = '{ST,  3'b001, 32'h202, 32'h0000BEEF, 32'h0,        5'd4,  1'b1, 1'b1, 32'h200, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[2]  = '{LD,  3'b101, 32'h10,  32'h0,        32'h12348001, 5'd5,  1'b1, 1'b1, 32'h10,  1'b0, 4'h0,    32'h0,        1'b1, 32'h00008001, 1'b0, 2'b00};
        vecs[3]  = '{LD,  3'b010, 32'h6,   32'h0,        32'h0,        5'd6,  1'b0, 1'b0, 32'h0,   1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 2'b01};
        vecs[4]  = '{ST,  3'b000, 32'h1,   32'h000000A5, 32'h0,        5'd7,  1'b1, 1'b1, 32'h0,   1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[5]  = '{ST,  3'b010, 32'h40,  32'hDEADBEEF, 32'h0,        5'd8,  1'b1, 1'b1, 32'h40,  1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[6]  = '{LD,  3'b000, 32'h2,   32'h0,        32'h007F0000, 5'd9,  1'b1, 1'b1, 32'h0,   1'b0, 4'h0,    32'h0,        1'b1, 32'h0000007F, 1'b0, 2'b00};
        vecs[7]  = '{LD,  3'b001, 32'h6,   32'h0,        32'h9ABC0000, 5'd10, 1'b1, 1'b1, 32'h4,   1'b0, 4'h0,    32'h0,        1'b1, 32'hFFFF9ABC, 1'b0, 2'b00};
        vecs[8]  = '{LD,  3'b100, 32'h3,   32'h0,        32'hF0000000, 5'd11, 1'b1, 1'b1, 32'h0,   1'b0, 4'h0,    32'h0,        1'b1, 32'h000000F0, 1'b0, 2'b00};
        vecs[9]  = '{LD,  3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 5'd12, 1'b1, 1'b1, 32'h20,  1'b0, 4'h0,    32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 2'b00};
        vecs[10] = '{LD,  3'b001, 32'h5,   32'h0,        32'h0,        5'd13, 1'b0, 1'b0, 32'h0,   1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 2'b01};
        vecs[11] = '{LD,  3'b011, 32'h8,   32'h0,        32'h0,        5'd14, 1'b0, 1'b0, 32'h0,   1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 2'b10};
        vecs[12] = '{ST,  3'b100, 32'h0,   32'h1,        32'h0,        5'd15, 1'b0, 1'b0, 32'h0,   1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 2'b10};
        vecs[13] = '{ST,  3'b001, 32'h3,   32'h1,        32'h0,        5'd16, 1'b0, 1'b0, 32'h0,   1'b0, 4'h0,    32'h0,        1'b0, 32'h0,        1'b1, 2'b01};

        rst = 1'b1; valid_in = 1'b0; opcode = 7'd0; funct3 = 3'd0; result = 32'd0;
        data = 32'd0; rd_in = 5'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", stall, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset wb_valid", wb_valid, 0);
        chk("reset mem_err", mem_err, 0);
        chk("reset rdMem", rdMem, 0);
        chk("reset wstrb", mem_wstrb, 0);
        chk("reset err_cause", err_cause, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].d, vecs[i].rd);
            #1;
            chk($sformatf("v%0d stall_issue", i), stall, vecs[i].exp_stall);
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            chk($sformatf("v%0d mem_req", i), mem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].exp_we);
                chk($sformatf("v%0d mem_wstrb", i), mem_wstrb, vecs[i].exp_wstrb);
                if (vecs[i].exp_we)
                    chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
                mem_ack   = 1'b1;
                mem_rdata = vecs[i].rdata;
                #1;
                chk($sformatf("v%0d stall_ack", i), stall, 0);
                @(negedge clk);
                mem_ack = 1'b0;
                #1;
                chk($sformatf("v%0d mem_req_after", i), mem_req, 0);
            end
            chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].exp_wb);
            if (vecs[i].exp_wb) begin
                chk($sformatf("v%0d rdMem", i), rdMem, vecs[i].exp_rdmem);
                chk($sformatf("v%0d wb_rd", i), wb_rd, vecs[i].rd);
            end
            chk($sformatf("v%0d mem_err", i), mem_err, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d err_cause", i), err_cause, vecs[i].exp_cause);
                chk($sformatf("v%0d err_addr", i), err_addr, vecs[i].a);
            end
            @(negedge clk);
        end

        // LB with ack arriving in the 4th WAIT cycle (also the last count before timeout)
        stalls = 0;
        drive(LD, 3'b000, 32'h103, 32'h0, 5'd20);
        #1;
        if (stall) stalls++;
        @(negedge clk);
        valid_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            mem_ack   = (k == 4);
            mem_rdata = 32'h80FFFF00;
            #1;
            if (stall) stalls++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        #1;
        chk("lb stall_cycles", stalls, 4);
        chk("lb wb_valid", wb_valid, 1);
        chk("lb rdMem", rdMem, 32'hFFFFFF80);
        chk("lb wb_rd", wb_rd, 5'd20);
        chk("lb mem_err", mem_err, 0);
        @(negedge clk);
        chk("lb wb_pulse", wb_valid, 0);

        // load never acked; valid_in during WAIT must be ignored
        req_cycles = 0;
        drive(LD, 3'b010, 32'h30, 32'h0, 5'd21);
        @(negedge clk);
        drive(ALU, 3'b000, 32'h77, 32'h0, 5'd22);
        for (int k = 0; k < 20 && mem_req; k++) begin
            req_cycles++;
            #1;
            chk("to stall_wait", stall, 1);
            @(negedge clk);
            if (mem_req) chk("to wb_ignored", wb_valid, 0);
        end
        valid_in = 1'b0;
        #1;
        chk("to req_cycles", req_cycles, 4);
        chk("to mem_req_low", mem_req, 0);
        chk("to mem_err", mem_err, 1);
        chk("to err_cause", err_cause, 2'b11);
        chk("to err_addr", err_addr, 32'h30);
        chk("to wb_valid", wb_valid, 0);
        @(negedge clk);
        chk("to err_pulse", mem_err, 0);
        drive(ALU, 3'b000, 32'h9, 32'h0, 5'd2);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk("hold err_cause", err_cause, 2'b11);
        chk("alu rdMem", rdMem, 32'h9);

        // reset in the second WAIT cycle, then a late ack
        drive(LD, 3'b010, 32'h44, 32'h0, 5'd23);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h13572468;
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst mem_err", mem_err, 0);
        chk("rst stall", stall, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rst late_ack_wb", wb_valid, 0);
        chk("rst late_ack_req", mem_req, 0);
        drive(ALU, 3'b000, 32'h5, 32'h0, 5'd1);
        #1;
        chk("add stall", stall, 0);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk("add wb_valid", wb_valid, 1);
        chk("add rdMem", rdMem, 32'h5);
        chk("add wb_rd", wb_rd, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
